// File: rtl/prng_shift_ctrl.sv
// prng_shift_ctrl: two-requester front end for a 16-bit Galois LFSR.
// A granted requester gets one word produced by STEPS shift cycles; grants
// alternate by round-robin when both requesters are asking.
// Optional build macro: PRNG_SHIFT_CTRL_ZERO_GUARD_EN -- when defined, a seed
// of 16'h0000 is replaced by 16'h0001 on load so the LFSR cannot lock up.
module prng_shift_ctrl #(
  parameter int unsigned STEPS    = 16,
  parameter logic [15:0] TAPS     = 16'hB400,
  parameter logic [15:0] RST_SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        seed_load,
  input  logic [15:0] seed_in,
  input  logic [1:0]  req,
  output logic [1:0]  gnt,
  output logic [1:0]  done,
  output logic [15:0] rnd_out,
  output logic        busy
);

  // Counter must hold 0..STEPS-1; one extra value of headroom keeps the
  // free-running increment from wrapping before the DONE transition.
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEPS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e            fsm_q;
  logic [15:0]       lfsr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              ptr_q;     // index of the requester preferred on a tie
  logic [1:0]        gnt_q;
  logic [1:0]        done_q;
  logic [15:0]       rnd_q;
  logic              busy_q;

  logic [15:0]       seed_eff;
  logic [1:0]        win;

  // One Galois step: shift right, fold the taps back in when a 1 falls out.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? TAPS : 16'h0000);
  endfunction

`ifdef PRNG_SHIFT_CTRL_ZERO_GUARD_EN
  // An all-zero Galois LFSR never leaves zero, so substitute the smallest
  // non-zero seed instead.
  assign seed_eff = (seed_in == 16'h0000) ? 16'h0001 : seed_in;
`else
  assign seed_eff = seed_in;
`endif

  // Round-robin winner: a lone request always wins, a tie goes to ptr_q.
  // The two terms are mutually exclusive, so win is one-hot or zero.
  for (genvar gi = 0; gi < 2; gi++) begin : g_arb
    assign win[gi] = req[gi] & (~req[1-gi] | (ptr_q == 1'(gi)));
  end

  // Controller FSM; every output is a register updated here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q  <= ST_IDLE;
      lfsr_q <= RST_SEED;
      cnt_q  <= '0;
      ptr_q  <= 1'b0;
      gnt_q  <= 2'b00;
      done_q <= 2'b00;
      rnd_q  <= 16'h0000;
      busy_q <= 1'b0;
    end else begin
      // done is a single-cycle pulse; only the DONE state raises it.
      done_q <= 2'b00;
      case (fsm_q)
        ST_IDLE: begin
          if (seed_load) begin
            // Seeding wins over a same-cycle request; the request is simply
            // seen again on the next IDLE cycle.
            lfsr_q <= seed_eff;
          end else if (|req) begin
            gnt_q  <= win;
            cnt_q  <= '0;
            busy_q <= 1'b1;
            fsm_q  <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          // seed_load is deliberately not looked at while a word is in flight.
          lfsr_q <= lfsr_step(lfsr_q);
          cnt_q  <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            fsm_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          rnd_q  <= lfsr_q;
          done_q <= gnt_q;
          // Hand preference to whoever was not just served.
          ptr_q  <= gnt_q[0];
          gnt_q  <= 2'b00;
          busy_q <= 1'b0;
          fsm_q  <= ST_IDLE;
        end
        default: begin
          fsm_q  <= ST_IDLE;
          gnt_q  <= 2'b00;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign gnt     = gnt_q;
  assign done    = done_q;
  assign rnd_out = rnd_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_prng_shift_ctrl.sv
// Testbench for prng_shift_ctrl: one instance with STEPS=1 and one with
// STEPS=16, checked against a scoreboard fed by a behavioural LFSR model.
module tb_prng_shift_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance 0: STEPS=1
  logic        rst1_n = 1'b0;
  logic        seed_load1 = 1'b0;
  logic [15:0] seed_in1 = 16'h0;
  logic [1:0]  req1 = 2'b00;
  logic [1:0]  gnt1, done1;
  logic [15:0] rnd1;
  logic        busy1;

  // Instance 1: STEPS=16
  logic        rst16_n = 1'b0;
  logic        seed_load16 = 1'b0;
  logic [15:0] seed_in16 = 16'h0;
  logic [1:0]  req16 = 2'b00;
  logic [1:0]  gnt16, done16;
  logic [15:0] rnd16;
  logic        busy16;

  prng_shift_ctrl #(.STEPS(1)) u_dut1 (
    .clk(clk), .rst_n(rst1_n), .seed_load(seed_load1), .seed_in(seed_in1),
    .req(req1), .gnt(gnt1), .done(done1), .rnd_out(rnd1), .busy(busy1)
  );

  prng_shift_ctrl #(.STEPS(16)) u_dut16 (
    .clk(clk), .rst_n(rst16_n), .seed_load(seed_load16), .seed_in(seed_in16),
    .req(req16), .gnt(gnt16), .done(done16), .rnd_out(rnd16), .busy(busy16)
  );

  typedef struct packed {
    logic [1:0]  d;
    logic [15:0] r;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] mstate [2];
  logic        mptr   [2];
  int          checks = 0;
  int          failures = 0;

  // Reference LFSR, written bit-wise rather than with a shift operator.
  function automatic logic [15:0] model_run(input logic [15:0] s, input int n);
    logic [15:0] t;
    t = s;
    for (int i = 0; i < n; i++) begin
      if (t[0]) t = {1'b0, t[15:1]} ^ 16'hB400;
      else      t = {1'b0, t[15:1]};
    end
    return t;
  endfunction

  function automatic logic [15:0] guard(input logic [15:0] v);
`ifdef PRNG_SHIFT_CTRL_ZERO_GUARD_EN
    return (v == 16'h0000) ? 16'h0001 : v;
`else
    return v;
`endif
  endfunction

  function automatic logic [1:0]  get_done(input int w); return (w == 0) ? done1 : done16; endfunction
  function automatic logic [1:0]  get_gnt (input int w); return (w == 0) ? gnt1  : gnt16;  endfunction
  function automatic logic [15:0] get_rnd (input int w); return (w == 0) ? rnd1  : rnd16;  endfunction
  function automatic logic        get_busy(input int w); return (w == 0) ? busy1 : busy16; endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int w, input logic [1:0] v);
    if (w == 0) req1 = v; else req16 = v;
  endtask

  task automatic set_seed(input int w, input logic ld, input logic [15:0] v);
    if (w == 0) begin seed_load1 = ld; seed_in1 = v; end
    else        begin seed_load16 = ld; seed_in16 = v; end
  endtask

  task automatic load_seed(input int w, input logic [15:0] v);
    set_seed(w, 1'b1, v);
    tick();
    set_seed(w, 1'b0, 16'h0000);
    mstate[w] = guard(v);
  endtask

  // One request/done transaction. drop_at>0 releases req after that many
  // edges, keep leaves req asserted afterwards, pulse_at>0 pulses seed_load
  // with 16'hFFFF during the sequence.
  task automatic run_txn(input int w, input logic [1:0] r, input int drop_at,
                         input bit keep, input int pulse_at,
                         output logic [1:0] obs_done, output logic [15:0] obs_rnd);
    exp_t       e;
    logic [1:0] eg;
    int         n;
    bit         seen;
    int         steps;
    steps = (w == 0) ? 1 : 16;
    eg = (r == 2'b11) ? (mptr[w] ? 2'b10 : 2'b01) : r;
    mstate[w] = model_run(mstate[w], steps);
    mptr[w] = eg[0];
    e.d = eg;
    e.r = mstate[w];
    sb.push_back(e);
    set_req(w, r);
    n = 0;
    seen = 1'b0;
    obs_done = 2'b00;
    obs_rnd = 16'h0000;
    while (!seen && n < 200) begin
      tick();
      n++;
      if (n == 1) begin
        checks++;
        if (get_gnt(w) !== eg || get_busy(w) !== 1'b1) begin
          failures++;
          $display("FAIL grant_entry dut%0d: gnt=%b busy=%b required gnt=%b busy=1", w, get_gnt(w), get_busy(w), eg);
        end
        checks++;
        if (get_done(w) !== 2'b00) begin
          failures++;
          $display("FAIL done_pulse_width dut%0d: done=%b required 00", w, get_done(w));
        end
      end
      if (drop_at > 0 && n == drop_at) set_req(w, 2'b00);
      if (pulse_at > 0 && n == pulse_at) set_seed(w, 1'b1, 16'hFFFF);
      if (pulse_at > 0 && n == pulse_at + 1) set_seed(w, 1'b0, 16'h0000);
      if (get_done(w) !== 2'b00) seen = 1'b1;
    end
    set_seed(w, 1'b0, 16'h0000);
    e = sb.pop_front();
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL done_timeout dut%0d: no done within %0d edges, required done=%b", w, n, e.d);
    end else begin
      obs_done = get_done(w);
      obs_rnd = get_rnd(w);
      $display("txn dut%0d req=%b done=%b rnd=%h expected done=%b rnd=%h lat=%0d", w, r, obs_done, obs_rnd, e.d, e.r, n - 1);
      checks++;
      if (obs_done !== e.d) begin
        failures++;
        $display("FAIL done_vector dut%0d: done=%b required %b", w, obs_done, e.d);
      end
      checks++;
      if (obs_rnd !== e.r) begin
        failures++;
        $display("FAIL rnd_out dut%0d: rnd=%h required %h", w, obs_rnd, e.r);
      end
      checks++;
      if (n - 1 != steps + 1) begin
        failures++;
        $display("FAIL latency dut%0d: %0d edges required %0d", w, n - 1, steps + 1);
      end
      checks++;
      if (get_gnt(w) !== 2'b00 || get_busy(w) !== 1'b0) begin
        failures++;
        $display("FAIL idle_after_done dut%0d: gnt=%b busy=%b required 00/0", w, get_gnt(w), get_busy(w));
      end
    end
    if (!keep) set_req(w, 2'b00);
  endtask

  task automatic check_outputs_zero(input int w, input string tag);
    checks++;
    if (get_gnt(w) !== 2'b00 || get_done(w) !== 2'b00 || get_rnd(w) !== 16'h0000 || get_busy(w) !== 1'b0) begin
      failures++;
      $display("FAIL %s dut%0d: gnt=%b done=%b rnd=%h busy=%b required all zero", tag, w, get_gnt(w), get_done(w), get_rnd(w), get_busy(w));
    end
  endtask

  task automatic test_reset();
    tick();
    tick();
    check_outputs_zero(0, "reset_state");
    check_outputs_zero(1, "reset_state");
    rst1_n = 1'b1;
    rst16_n = 1'b1;
    mstate[0] = 16'hACE1; mptr[0] = 1'b0;
    mstate[1] = 16'hACE1; mptr[1] = 1'b0;
    tick();
    check_outputs_zero(0, "post_reset_idle");
  endtask

  task automatic test_single_step();
    logic [1:0] d;
    logic [15:0] r;
    load_seed(0, 16'h0001);
    run_txn(0, 2'b01, 0, 1'b0, 0, d, r);
    checks++;
    if (d !== 2'b01 || r !== 16'hB400) begin
      failures++;
      $display("FAIL seed1_vector: done=%b rnd=%h required 01/b400", d, r);
    end
    // Pointer now favours requester 1, but a lone request 0 must still win.
    load_seed(0, 16'h0001);
    run_txn(0, 2'b01, 0, 1'b0, 0, d, r);
    checks++;
    if (d !== 2'b01) begin
      failures++;
      $display("FAIL lone_request: done=%b required 01", d);
    end
    load_seed(0, 16'h0002);
    run_txn(0, 2'b10, 0, 1'b0, 0, d, r);
    checks++;
    if (d !== 2'b10 || r !== 16'h0001) begin
      failures++;
      $display("FAIL seed2_vector: done=%b rnd=%h required 10/0001", d, r);
    end
  endtask

  task automatic test_zero_seed();
    logic [1:0] d;
    logic [15:0] r;
    logic [15:0] exp_first;
`ifdef PRNG_SHIFT_CTRL_ZERO_GUARD_EN
    exp_first = 16'hB400;
`else
    exp_first = 16'h0000;
`endif
    load_seed(0, 16'h0000);
    run_txn(0, 2'b01, 0, 1'b0, 0, d, r);
    checks++;
    if (r !== exp_first) begin
      failures++;
      $display("FAIL zero_seed: rnd=%h required %h", r, exp_first);
    end
    run_txn(0, 2'b10, 0, 1'b0, 0, d, r);
  endtask

  task automatic test_round_robin();
    logic [1:0] d;
    logic [15:0] r;
    logic [1:0] order [4];
    order[0] = 2'b01; order[1] = 2'b10; order[2] = 2'b01; order[3] = 2'b10;
    rst1_n = 1'b0;
    tick();
    rst1_n = 1'b1;
    mstate[0] = 16'hACE1;
    mptr[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      run_txn(0, 2'b11, 0, 1'b1, 0, d, r);
      checks++;
      if (d !== order[i]) begin
        failures++;
        $display("FAIL rr_order[%0d]: done=%b required %b", i, d, order[i]);
      end
    end
    set_req(0, 2'b00);
    tick();
  endtask

  task automatic test_latency16();
    logic [1:0] d;
    logic [15:0] r;
    run_txn(1, 2'b01, 0, 1'b0, 0, d, r);
  endtask

  task automatic test_drop_mid_shift();
    logic [1:0] d;
    logic [15:0] r;
    run_txn(1, 2'b10, 3, 1'b0, 0, d, r);
    checks++;
    if (d !== 2'b10) begin
      failures++;
      $display("FAIL drop_mid_shift: done=%b required 10", d);
    end
  endtask

  task automatic test_seed_ignored();
    logic [1:0] d;
    logic [15:0] r;
    load_seed(1, 16'h1234);
    run_txn(1, 2'b01, 0, 1'b0, 5, d, r);
    run_txn(1, 2'b01, 0, 1'b0, 0, d, r);
  endtask

  task automatic test_reset_mid_shift();
    logic [1:0] d;
    logic [15:0] r;
    bit stray;
    set_req(1, 2'b10);
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (gnt16 !== 2'b10 || busy16 !== 1'b1) begin
      failures++;
      $display("FAIL pre_abort_shift: gnt=%b busy=%b required 10/1", gnt16, busy16);
    end
    #2;
    rst16_n = 1'b0;
    #1;
    check_outputs_zero(1, "async_reset");
    set_req(1, 2'b00);
    stray = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done16 !== 2'b00) stray = 1'b1;
    end
    checks++;
    if (stray) begin
      failures++;
      $display("FAIL abort_no_done: done pulsed after reset, required none");
    end
    rst16_n = 1'b1;
    mstate[1] = 16'hACE1;
    mptr[1] = 1'b0;
    tick();
    run_txn(1, 2'b11, 0, 1'b0, 0, d, r);
    checks++;
    if (d !== 2'b01 || r !== model_run(16'hACE1, 16)) begin
      failures++;
      $display("FAIL restart_after_abort: done=%b rnd=%h required 01/%h", d, r, model_run(16'hACE1, 16));
    end
  endtask

  initial begin
    test_reset();
    test_single_step();
    test_zero_seed();
    test_round_robin();
    test_latency16();
    test_drop_mid_shift();
    test_seed_ignored();
    test_reset_mid_shift();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/prng_shift_ctrl.md
PRNG_SHIFT_CTRL -- requirements
Module: prng_shift_ctrl

Interface
REQ-001 SHALL expose parameter STEPS, default 16, meaning the number of shift steps per generated word (legal range 1..64).
REQ-002 SHALL expose parameter TAPS, default 16'hB400, meaning the Galois feedback mask XORed in when the shifted-out bit is 1.
REQ-003 SHALL expose parameter RST_SEED, default 16'hACE1, meaning the state register value after reset.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 seed_load  input  1  load seed_in into state; accepted only in IDLE.
REQ-007 seed_in  input  16  seed value.
REQ-008 req  input  2  per-requester word request, level, held until matching done.
REQ-009 gnt  output  2  one-hot grant, registered, high from SHIFT entry through DONE.
REQ-010 done  output  2  one-hot, one-cycle pulse; rnd_out valid for that requester.
REQ-011 rnd_out  output  16  generated word, holds last value until the next DONE.
REQ-012 busy  output  1  high in SHIFT and DONE.

Function
REQ-013 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-014 IDLE: seed_load=1 SHALL load state and stay in IDLE, with seed_load taking priority over req in the same cycle.
REQ-015 IDLE: seed_load=0 with any req bit set SHALL grant one requester by round-robin pointer, set gnt, clear step counter, go to SHIFT.
REQ-016 Round-robin: pointer reset value 0; req=2'b11 grants the pointer index; a single request is granted regardless of pointer.
REQ-017 SHIFT: each cycle state <= (state >> 1) ^ (state[0] ? TAPS : 16'h0000), with the counter incrementing.
REQ-018 SHIFT SHALL last exactly STEPS cycles, then go to DONE.
REQ-019 DONE (one cycle): rnd_out <= state, the granted done bit pulses, the pointer moves to the other requester, gnt clears on exit, next state IDLE.
REQ-020 Latency: done SHALL assert STEPS+1 rising edges after the edge that sampled req in IDLE.
REQ-021 seed_load in SHIFT/DONE SHALL be ignored (not queued), and state SHALL continue unaffected.
REQ-022 Requester dropping req mid-SHIFT: the sequence SHALL complete and done SHALL still pulse for that requester.
REQ-023 A requester still holding req after its done SHALL be eligible again in the next IDLE, subject to the pointer.
REQ-024 Minimum spacing between consecutive grants SHALL be one IDLE cycle.

Reset
REQ-025 rst_n=0 SHALL immediately force state IDLE, state register=RST_SEED, counter=0, pointer=0, gnt=0, done=0, rnd_out=0, busy=0.
REQ-026 Reset mid-SHIFT SHALL abort the sequence with no done pulse, and the next operation SHALL start from RST_SEED.

Configuration
REQ-027 Macro PRNG_SHIFT_CTRL_ZERO_GUARD_EN defined: seed_load with seed_in=16'h0000 SHALL load 16'h0001 (avoid LFSR lock-up).
REQ-028 Macro not defined: seed_in SHALL load unmodified, and a zero seed SHALL yield rnd_out=16'h0000 on every request.

Verification
REQ-029 STEPS=1, seed_load 16'h0001, req=2'b01 -> gnt=2'b01 next cycle, done[0] pulse 2 edges after req, rnd_out=16'hB400.
REQ-030 STEPS=1, seed_load 16'h0002, req=2'b10 -> done[1] pulse, rnd_out=16'h0001.
REQ-031 After reset, req=2'b11 held -> grant order 0,1,0,1, with done pulses alternating and no back-to-back grants without an IDLE cycle.
REQ-032 seed_load 16'h0000 -> with macro, STEPS=1 rnd_out=16'hB400; without macro, rnd_out=16'h0000.
REQ-033 STEPS=16, rst_n low at 5th SHIFT cycle -> all outputs 0 immediately, no done; subsequent req yields the same rnd_out as a fresh-from-reset run.
REQ-034 seed_load pulsed during SHIFT -> ignored; rnd_out matches a reference model run without the pulse.
